// File: rtl/spi_pkg.sv
`default_nettype none
// =====================================================================
// Module : spi_pkg -- FSM encoding, SPI mode constants, counter sizing
// Rev    : 1.0
// =====================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  localparam logic c_cpol0 = 1'b0;
  localparam logic c_cpol1 = 1'b1;
  localparam logic c_cpha0 = 1'b0;
  localparam logic c_cpha1 = 1'b1;

  // Edge counter must hold the terminal value 2*DATA_W.
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// =====================================================================
// Module : spi_clk_div -- half-period tick generator, counts 0..div_i
// Rev    : 1.0
// =====================================================================
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == div_i);

  // Registered tick: fires one cycle after the count reaches div_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr_i || !en_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: rtl/spi_master_tri.sv
`default_nettype none
// =====================================================================
// Module : spi_master_tri -- SPI master with pad I/T/O control
//          (SPI_3WIRE_EN adds dir_rx_i / mosi_i for half-duplex MOSI)
// Rev    : 1.0
// =====================================================================
module spi_master_tri
  import spi_pkg::*;
#(
  parameter  int NBR_OF_SLAVE = 3,
  parameter  int DATA_W       = 16,
  parameter  int DIV_W        = 8,
  parameter  int CS_GAP       = 2,
  localparam int SLV_W        = (NBR_OF_SLAVE > 1) ? $clog2(NBR_OF_SLAVE) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [SLV_W-1:0]        slave_i,
  input  logic [DATA_W-1:0]       tx_data_i,
  input  logic                    cpol_i,
  input  logic                    cpha_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic                    pad_en_i,
`ifdef SPI_3WIRE_EN
  input  logic                    dir_rx_i,
  input  logic                    mosi_i,
`endif
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [DATA_W-1:0]       rx_data_o,
  output logic                    mosi_o,
  output logic                    mosi_t_o,
  input  logic                    miso_i,
  output logic                    sck_o,
  output logic                    sck_t_o,
  output logic [NBR_OF_SLAVE-1:0] ss_o,
  output logic                    ss_t_o
);

  localparam int EW = edge_cnt_w(DATA_W);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [EW-1:0]           c_edge_last = EW'(2 * DATA_W - 1);
  localparam logic [GW-1:0]           c_gap_last  = GW'(CS_GAP - 1);
  localparam logic [NBR_OF_SLAVE-1:0] c_ss_one    = NBR_OF_SLAVE'(1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  spi_state_t        r_state, w_next;
  logic              w_busy, w_done, w_tick, w_accept, w_slave_ok;
  logic              w_sample_edge, w_rx_bit, w_pads_on, w_mosi_rx;
  logic [SLV_W-1:0]  r_slave;
  logic              r_cpha, r_sck, r_mosi, r_err;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [GW-1:0]     r_gap;
  logic [EW-1:0]     r_edge;

  // Reset asserts asynchronously, releases two clocks after rstn_i rises.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk_i  (clk_i),
    .rstn_i (w_rst_n),
    .en_i   (w_busy),
    .clr_i  (r_state == ST_IDLE),
    .div_i  (r_div),
    .tick_o (w_tick)
  );

  assign w_slave_ok = 32'(slave_i) < NBR_OF_SLAVE;
  assign w_accept   = (r_state == ST_IDLE) && start_i && w_slave_ok;

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)                       w_next = ST_SETUP;
      ST_SETUP: if (w_tick && r_gap == c_gap_last)   w_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && r_edge == c_edge_last) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick && r_gap == c_gap_last)   w_next = ST_DONE;
      ST_DONE:                                      w_next = ST_IDLE;
      default:                                      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_SETUP, ST_SHIFT, ST_HOLD: w_busy = 1'b1;
      ST_DONE:                     w_done = 1'b1;
      default:                     ;
    endcase
  end

`ifdef SPI_3WIRE_EN
  logic r_dir_rx;
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n)      r_dir_rx <= 1'b0;
    else if (w_accept) r_dir_rx <= dir_rx_i;
  end
  assign w_rx_bit  = r_dir_rx ? mosi_i : miso_i;
  assign w_mosi_rx = r_dir_rx && (r_state == ST_SHIFT);
`else
  assign w_rx_bit  = miso_i;
  assign w_mosi_rx = 1'b0;
`endif

  // Odd edges have r_edge[0] == 0; CPHA selects which parity samples.
  assign w_sample_edge = (r_edge[0] == (r_cpha == c_cpha1));

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_slave   <= '0;
      r_cpha    <= c_cpha0;
      r_div     <= '0;
      r_sck     <= c_cpol0;
      r_mosi    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_gap     <= '0;
      r_edge    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && start_i && !w_slave_ok;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_slave <= slave_i;
          r_cpha  <= cpha_i;
          r_div   <= div_i;
          r_sck   <= cpol_i ? c_cpol1 : c_cpol0;
          // CPHA0 presents the MSB before the first edge; CPHA1 on it.
          r_mosi  <= (cpha_i == c_cpha0) ? tx_data_i[DATA_W-1] : 1'b0;
          r_tx    <= (cpha_i == c_cpha0) ? {tx_data_i[DATA_W-2:0], 1'b0} : tx_data_i;
          r_rx    <= '0;
          r_gap   <= '0;
          r_edge  <= '0;
        end
        ST_SETUP, ST_HOLD: if (w_tick) begin
          r_gap <= (r_gap == c_gap_last) ? '0 : r_gap + 1'b1;
          if (r_state == ST_HOLD && r_gap == c_gap_last) r_rx_data <= r_rx;
        end
        ST_SHIFT: if (w_tick) begin
          r_sck  <= ~r_sck;
          r_edge <= r_edge + 1'b1;
          if (w_sample_edge) begin
            r_rx <= {r_rx[DATA_W-2:0], w_rx_bit};
          end else begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_pads_on = pad_en_i & w_rst_n;

  assign busy_o    = w_busy;
  assign done_o    = w_done;
  assign err_o     = r_err;
  assign rx_data_o = r_rx_data;
  assign mosi_o    = r_mosi;
  assign sck_o     = r_sck;
  assign ss_o      = w_busy ? ~(c_ss_one << r_slave) : '1;
  assign mosi_t_o  = ~w_pads_on | w_mosi_rx;
  assign sck_t_o   = ~w_pads_on;
  assign ss_t_o    = ~w_pads_on;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tri.sv
`default_nettype none
// =====================================================================
// Module : tb_spi_master_tri -- directed scoreboard bench, 4-wire build
// Rev    : 1.0
// =====================================================================
module tb_spi_master_tri;
  import spi_pkg::*;

  localparam int NTICK = 2 * 2 + 2 * 16;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  slave_i = '0;
  logic [15:0] tx_data_i = '0;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [7:0]  div_i = '0;
  logic        pad_en_i = 1'b1;
  logic        miso_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] rx_data_o;
  logic        mosi_o, mosi_t_o, sck_o, sck_t_o, ss_t_o;
  logic [2:0]  ss_o;

  logic        loop_en = 1'b1;
  logic        cpha_m = 1'b0;
  logic        in_xfer = 1'b0;
  logic        last_sck = 1'b0;
  logic        slv_bit;
  logic [15:0] slv_word = 16'h3C5A;
  int          k = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  spi_master_tri #(.NBR_OF_SLAVE(3), .DATA_W(16), .DIV_W(8), .CS_GAP(2)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .slave_i(slave_i),
    .tx_data_i(tx_data_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .div_i(div_i),
    .pad_en_i(pad_en_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rx_data_o(rx_data_o), .mosi_o(mosi_o), .mosi_t_o(mosi_t_o), .miso_i(miso_i),
    .sck_o(sck_o), .sck_t_o(sck_t_o), .ss_o(ss_o), .ss_t_o(ss_t_o)
  );

  always #5 clk = ~clk;

  // Slave model: counts SCK edges and presents slv_word MSB first.
  always @(sck_o, in_xfer) begin
    if (!in_xfer) k = 0;
    else if (sck_o !== last_sck) k = k + 1;
    last_sck = sck_o;
  end

  always_comb begin
    int idx;
    idx = 15;
    if (!cpha_m) idx = 15 - k / 2;
    else if (k > 0) idx = 15 - (k - 1) / 2;
    if (idx < 0) idx = 0;
    slv_bit = slv_word[idx[3:0]];
  end

  assign miso_i = loop_en ? mosi_o : slv_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input logic [1:0] slv, input logic [15:0] tx, input logic pol,
                         input logic pha, input logic [7:0] dv, input logic lp,
                         input logic hold, input int pad_off_at, input logic cmp_rx);
    int lat;
    int exp_lat;
    logic [15:0] exp_rx;
    exp_lat = NTICK * (int'(dv) + 1) + 2;
    @(negedge clk);
    slave_i = slv; tx_data_i = tx; cpol_i = pol; cpha_i = pha; div_i = dv;
    loop_en = lp; cpha_m = pha; start_i = 1'b1;
    exp_q.push_back(lp ? tx : slv_word);
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    // Disturb every configuration input; the transfer must use latched copies.
    tx_data_i = ~tx; cpol_i = ~pol; cpha_i = ~pha; div_i = 8'd0;
    in_xfer = 1'b1;
    check("setup_ss", 32'(ss_o), 32'(3'b111 & ~(3'b001 << slv)));
    check("setup_busy", 32'(busy_o), 32'd1);
    check("setup_sck", 32'(sck_o), 32'(pol));
    if (!pha) check("setup_mosi", 32'(mosi_o), 32'(tx[15]));
    lat = -1;
    for (int c = 2; c <= exp_lat + 20; c++) begin
      @(negedge clk);
      if (pad_off_at > 0 && c == pad_off_at) begin
        pad_en_i = 1'b0; #1;
        check("padoff_t", 32'({mosi_t_o, sck_t_o, ss_t_o}), 32'h7);
      end
      if (pad_off_at > 0 && c == pad_off_at + 10) begin
        pad_en_i = 1'b1; #1;
        check("padon_t", 32'({mosi_t_o, sck_t_o, ss_t_o}), 32'h0);
      end
      if (done_o) begin
        lat = c;
        break;
      end
    end
    in_xfer = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      exp_rx = exp_q.pop_front();
      if (cmp_rx) check("rx_data", 32'(rx_data_o), 32'(exp_rx));
      check("done_busy", 32'(busy_o), 32'd0);
      check("done_sck_idle", 32'(sck_o), 32'(pol));
      check("done_ss", 32'(ss_o), 32'h7);
    end else begin
      exp_q.delete();
    end
    if (hold) start_i = 1'b0;
    @(negedge clk);
    check("post_idle", 32'({busy_o, done_o}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    // Reset values
    rstn_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy_o, done_o, err_o}), 32'h0);
    check("rst_rx", 32'(rx_data_o), 32'h0);
    check("rst_ss", 32'(ss_o), 32'h7);
    check("rst_sck_mosi", 32'({sck_o, mosi_o}), 32'h0);
    check("rst_t", 32'({mosi_t_o, sck_t_o, ss_t_o}), 32'h7);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk);
    check("pads_on", 32'({mosi_t_o, sck_t_o, ss_t_o}), 32'h0);

    // Loopback mode 0, fastest clock
    do_xfer(2'd0, 16'hA5C3, c_cpol0, c_cpha0, 8'd0, 1'b1, 1'b0, 0, 1'b1);
    // Slave model in modes 1, 2, 3
    do_xfer(2'd1, 16'h0000, c_cpol0, c_cpha1, 8'd3, 1'b0, 1'b0, 0, 1'b1);
    do_xfer(2'd2, 16'hFFFF, c_cpol1, c_cpha0, 8'd3, 1'b0, 1'b0, 0, 1'b1);
    do_xfer(2'd0, 16'h1234, c_cpol1, c_cpha1, 8'd3, 1'b0, 1'b0, 0, 1'b1);

    // Out-of-range slave index
    @(negedge clk);
    slave_i = 2'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("err_pulse", 32'(err_o), 32'd1);
    check("err_ss", 32'(ss_o), 32'h7);
    check("err_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'({err_o, busy_o}), 32'h0);

    // start held through a transfer, then a second start
    do_xfer(2'd0, 16'h1234, c_cpol0, c_cpha0, 8'd0, 1'b1, 1'b1, 0, 1'b1);
    do_xfer(2'd2, 16'h5AA5, c_cpol0, c_cpha0, 8'd0, 1'b1, 1'b0, 0, 1'b1);

    // Reset around SHIFT edge 7
    @(negedge clk);
    slave_i = 2'd1; tx_data_i = 16'hFFFF; cpol_i = 1'b0; cpha_i = 1'b0;
    div_i = 8'd0; loop_en = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_ss", 32'(ss_o), 32'h5);
    rstn_i = 1'b0;
    #1;
    check("abort_ss", 32'(ss_o), 32'h7);
    check("abort_t", 32'({mosi_t_o, sck_t_o, ss_t_o}), 32'h7);
    check("abort_busy", 32'(busy_o), 32'd0);
    nd = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 2) rstn_i = 1'b1;
      if (done_o) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    do_xfer(2'd1, 16'h0F0F, c_cpol0, c_cpha0, 8'd0, 1'b1, 1'b0, 0, 1'b1);

    // Pads released mid-transfer; transfer still completes on time
    do_xfer(2'd2, 16'hC001, c_cpol0, c_cpha0, 8'd1, 1'b1, 1'b0, 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
